// File: rtl/barrel_fetch_unit_if.sv
// Fetch-unit bus bundle: front-end control inputs, EX redirect,
// instruction BRAM port and the IF/ID-facing fetch result.
// master = barrel_fetch_unit, slave = the surrounding core/BRAM.
interface barrel_fetch_unit_if #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = 2,
  parameter int PC_W        = 9
);
  logic                   stall;
  logic [NUM_THREADS-1:0] thread_en;
  logic                   ex_branch_valid;
  logic [TID_W-1:0]       ex_branch_thread;
  logic [PC_W-1:0]        ex_branch_target;
  logic                   imem_en;
  logic [PC_W-1:0]        imem_addr;
  logic [31:0]            imem_inst;
  logic                   if_valid;
  logic [TID_W-1:0]       if_thread_id;
  logic [PC_W-1:0]        if_pc;
  logic [PC_W-1:0]        if_pc_plus4;
  logic [31:0]            if_instr;

  modport master (
    input  stall, thread_en, ex_branch_valid, ex_branch_thread, ex_branch_target,
    input  imem_inst,
    output imem_en, imem_addr,
    output if_valid, if_thread_id, if_pc, if_pc_plus4, if_instr
  );

  modport slave (
    output stall, thread_en, ex_branch_valid, ex_branch_thread, ex_branch_target,
    output imem_inst,
    input  imem_en, imem_addr,
    input  if_valid, if_thread_id, if_pc, if_pc_plus4, if_instr
  );
endinterface

// File: rtl/barrel_fetch_unit.sv
// Barrel fetch unit: one PC per hardware thread, fetched in fixed
// round-robin slot order through a two-stage F0 (address) / F1 (data) pipe.
// EX-stage redirects rewrite the owning thread's PC and squash its F0/F1
// entries. Disabled threads keep their slot so barrel timing never shifts.
// Optional: define BARREL_FETCH_RESET_VECTOR_EN to reset thread k's PC to
// k*THREAD_STRIDE instead of 0.
module barrel_fetch_unit #(
  parameter int              NUM_THREADS   = 4,
  parameter int              TID_W         = 2,
  parameter int              PC_W          = 9,
  parameter logic [PC_W-1:0] THREAD_STRIDE = PC_W'(9'h080)
) (
  input  logic               clk,
  input  logic               rstb,
  barrel_fetch_unit_if.master io_fetch
);

`ifdef BARREL_FETCH_RESET_VECTOR_EN
  localparam bit RESET_VECTOR_EN = 1'b1;
`else
  localparam bit RESET_VECTOR_EN = 1'b0;
`endif

  // Per-thread reset-vector spacing; zero collapses every thread onto address 0.
  localparam logic [PC_W-1:0] RESET_STRIDE = RESET_VECTOR_EN ? THREAD_STRIDE : '0;

  logic [TID_W-1:0] r_slot;
  logic [PC_W-1:0]  r_pc [NUM_THREADS];
  logic             r_f1_valid;
  logic [TID_W-1:0] r_f1_thread;
  logic [PC_W-1:0]  r_f1_pc;

  logic             w_run;
  logic             w_slot_en;
  logic             w_redirect_slot;
  logic             w_redirect_f1;
  logic [PC_W-1:0]  w_pc_f0;
  logic [PC_W-1:0]  w_tgt_aligned;

  // F0 address selection and redirect decode.
  always_comb begin
    w_run           = !io_fetch.stall;
    w_pc_f0         = r_pc[r_slot];
    w_slot_en       = io_fetch.thread_en[r_slot];
    w_tgt_aligned   = io_fetch.ex_branch_target & ~PC_W'(3);
    w_redirect_slot = io_fetch.ex_branch_valid && (io_fetch.ex_branch_thread == r_slot);
    w_redirect_f1   = io_fetch.ex_branch_valid && (io_fetch.ex_branch_thread == r_f1_thread);
  end

  // BRAM request: the BRAM output holds while stalled so F1 data stays aligned.
  assign io_fetch.imem_en   = w_run;
  assign io_fetch.imem_addr = w_pc_f0;

  // IF/ID-facing view of the F1 entry; instruction zeroed for bubbles.
  assign io_fetch.if_valid     = r_f1_valid;
  assign io_fetch.if_thread_id = r_f1_thread;
  assign io_fetch.if_pc        = r_f1_pc;
  assign io_fetch.if_pc_plus4  = r_f1_pc + PC_W'(4);
  assign io_fetch.if_instr     = r_f1_valid ? io_fetch.imem_inst : 32'h0;

  // Slot rotation and F1 capture; a held F1 entry can still be squashed.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_slot      <= '0;
      r_f1_valid  <= 1'b0;
      r_f1_thread <= '0;
      r_f1_pc     <= '0;
    end else if (w_run) begin
      r_slot      <= r_slot + TID_W'(1);
      r_f1_valid  <= w_slot_en && !w_redirect_slot;
      r_f1_thread <= r_slot;
      r_f1_pc     <= w_pc_f0;
    end else if (w_redirect_f1) begin
      r_f1_valid  <= 1'b0;
    end
  end

  // Per-thread PCs: redirect wins over the sequential +4 and ignores stall/enable.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < NUM_THREADS; k++) begin
        r_pc[k] <= PC_W'(k) * RESET_STRIDE;
      end
    end else begin
      for (int k = 0; k < NUM_THREADS; k++) begin
        if (io_fetch.ex_branch_valid && (io_fetch.ex_branch_thread == TID_W'(k))) begin
          r_pc[k] <= w_tgt_aligned;
        end else if (w_run && w_slot_en && (r_slot == TID_W'(k))) begin
          r_pc[k] <= r_pc[k] + PC_W'(4);
        end
      end
    end
  end

endmodule
